// File: rtl/alu_reservation_station_pkg.sv
// Shared Tomasulo types: ALU op encoding, issued ALU word, CDB broadcast and RS entry layout.
package tomasula_types;

  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ARITH = 3'd0,
    OP_IMM   = 3'd1,
    OP_LUI   = 3'd2,
    OP_AUIPC = 3'd3,
    OP_BR    = 3'd4,
    OP_JAL   = 3'd5,
    OP_LD    = 3'd6,
    OP_ST    = 3'd7
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] src1_data;
    logic [DATA_W-1:0] src2_data;
    logic [2:0]        funct3;
    logic              funct7;
    logic [TAG_W-1:0]  tag;
    logic              load;
  } alu_word_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_data_t;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rs_src_t;

  typedef struct packed {
    logic             busy;
    op_t              op;
    logic [2:0]       funct3;
    logic             funct7;
    logic [TAG_W-1:0] tag;
    rs_src_t          src1;
    rs_src_t          src2;
  } rs_entry_t;

  // A pending source picks up the broadcast value when its producer tag is on the CDB.
  function automatic rs_src_t src_snoop(input rs_src_t src, input cdb_data_t cdb);
    rs_src_t res;
    res = src;
    if (!src.rdy && cdb.valid && (cdb.tag == src.tag)) begin
      res.rdy  = 1'b1;
      res.data = cdb.data;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
interface alu_reservation_station_if;
  import tomasula_types::*;

  logic              disp_valid;
  logic              disp_ready;
  op_t               disp_op;
  logic [2:0]        disp_funct3;
  logic              disp_funct7;
  logic [TAG_W-1:0]  disp_tag;
  logic              disp_src1_valid;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [DATA_W-1:0] disp_src1_data;
  logic              disp_src2_valid;
  logic [TAG_W-1:0]  disp_src2_tag;
  logic [DATA_W-1:0] disp_src2_data;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              out_valid;
  logic              out_ready;
  alu_word_t         alu_word;

  modport master (
    output disp_valid, disp_op, disp_funct3, disp_funct7, disp_tag,
    output disp_src1_valid, disp_src1_tag, disp_src1_data,
    output disp_src2_valid, disp_src2_tag, disp_src2_data,
    output cdb_valid, cdb_tag, cdb_data,
    output out_ready,
    input  disp_ready, out_valid, alu_word
  );

  modport slave (
    input  disp_valid, disp_op, disp_funct3, disp_funct7, disp_tag,
    input  disp_src1_valid, disp_src1_tag, disp_src1_data,
    input  disp_src2_valid, disp_src2_tag, disp_src2_data,
    input  cdb_valid, cdb_tag, cdb_data,
    input  out_ready,
    output disp_ready, out_valid, alu_word
  );

endinterface

// File: rtl/alu_reservation_station_select.sv
// Lowest-index priority encoder used for free-slot and ready-slot selection.
module rs_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan from the top so the lowest set request wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops, snoops the CDB and issues ready ops in index order.
module alu_reservation_station
  import tomasula_types::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_WIDTH   = TAG_W,
  parameter int unsigned DATA_WIDTH  = DATA_W
) (
  input logic                      clk,
  input logic                      rst,
  alu_reservation_station_if.slave rs
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  rs_entry_t [NUM_ENTRIES-1:0] entries_q;
  rs_entry_t [NUM_ENTRIES-1:0] entries_d;
  logic                        out_valid_q;
  alu_word_t                   word_q;

  logic [NUM_ENTRIES-1:0] busy_c;
  logic [NUM_ENTRIES-1:0] free_c;
  logic [NUM_ENTRIES-1:0] ready_c;
  logic                   free_found_c;
  logic [IDX_W-1:0]       free_idx_c;
  logic                   ready_found_c;
  logic [IDX_W-1:0]       ready_idx_c;
  logic                   advance_c;
  logic                   disp_fire_c;
  logic                   issue_fire_c;
  alu_word_t              issue_word_c;
  rs_entry_t              issue_entry_c;

  // Broadcast viewed at the configured widths, then packed for the snoop helper.
  logic [TAG_WIDTH-1:0]  snoop_tag;
  logic [DATA_WIDTH-1:0] snoop_data;
  cdb_data_t             cdb;

  assign snoop_tag  = rs.cdb_tag;
  assign snoop_data = rs.cdb_data;
  assign cdb        = '{valid: rs.cdb_valid, tag: TAG_W'(snoop_tag), data: DATA_W'(snoop_data)};

  // Per-entry occupancy and operand readiness from registered state only.
  always_comb begin
    busy_c  = '0;
    ready_c = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      busy_c[i]  = entries_q[i].busy;
      ready_c[i] = entries_q[i].busy & entries_q[i].src1.rdy & entries_q[i].src2.rdy;
    end
  end

  assign free_c = ~busy_c;

  rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_free_sel (
    .req     (free_c),
    .found_c (free_found_c),
    .idx_c   (free_idx_c)
  );

  rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
    .req     (ready_c),
    .found_c (ready_found_c),
    .idx_c   (ready_idx_c)
  );

  assign rs.disp_ready = free_found_c;
  assign advance_c     = !out_valid_q | rs.out_ready;
  assign disp_fire_c   = rs.disp_valid & free_found_c;
  assign issue_fire_c  = advance_c & ready_found_c;

  // Word presented to the issue register when the lowest ready entry is taken.
  always_comb begin
    issue_entry_c          = entries_q[ready_idx_c];
    issue_word_c           = '0;
    issue_word_c.op        = issue_entry_c.op;
    issue_word_c.src1_data = issue_entry_c.src1.data;
    issue_word_c.src2_data = issue_entry_c.src2.data;
    issue_word_c.funct3    = issue_entry_c.funct3;
    issue_word_c.funct7    = issue_entry_c.funct7;
    issue_word_c.tag       = issue_entry_c.tag;
    issue_word_c.load      = 1'b1;
  end

  // Entry next-state: CDB capture, free on issue, fill on dispatch (targets a non-busy slot only).
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (entries_q[i].busy) begin
        entries_d[i].src1 = src_snoop(entries_q[i].src1, cdb);
        entries_d[i].src2 = src_snoop(entries_q[i].src2, cdb);
      end
      if (issue_fire_c && (ready_idx_c == IDX_W'(i))) begin
        entries_d[i].busy = 1'b0;
      end
      if (disp_fire_c && (free_idx_c == IDX_W'(i))) begin
        entries_d[i].busy   = 1'b1;
        entries_d[i].op     = rs.disp_op;
        entries_d[i].funct3 = rs.disp_funct3;
        entries_d[i].funct7 = rs.disp_funct7;
        entries_d[i].tag    = rs.disp_tag;
        entries_d[i].src1   = src_snoop('{rdy: rs.disp_src1_valid, tag: rs.disp_src1_tag,
                                          data: rs.disp_src1_data}, cdb);
        entries_d[i].src2   = src_snoop('{rdy: rs.disp_src2_valid, tag: rs.disp_src2_tag,
                                          data: rs.disp_src2_data}, cdb);
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  // Issue register: reload on advance, otherwise hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
    end else if (advance_c) begin
      if (ready_found_c) begin
        out_valid_q <= 1'b1;
        word_q      <= issue_word_c;
      end else begin
        out_valid_q <= 1'b0;
        word_q      <= '0;
      end
    end
  end

  assign rs.out_valid = out_valid_q;
  assign rs.alu_word  = word_q;

endmodule
